// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I-subset core: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7_5,
  input  logic                   zero,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic                   mem_write,
  output logic                   adr_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             result_src,
  output logic [2:0]             operation_control,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BEQ, S_JAL, S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b110;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] instret_q;
  logic [2:0]             r_op, i_op;
  logic                   r_ok, i_ok, retire;
  logic                   pc_update, branch, ir_we, reg_we, mem_we;

  // ALU function decode; an unsupported funct3 steers EXECUTE into ILLEGAL.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    r_op = ALU_ADD;
    r_ok = 1'b1;
    i_op = ALU_ADD;
    i_ok = 1'b1;
    case (funct3)
      3'b000: begin
        r_op = funct7_5 ? ALU_SUB : ALU_ADD;
        i_op = ALU_ADD;
      end
      3'b111: begin
        r_op = ALU_AND;
        i_op = ALU_AND;
      end
      3'b110: begin
        r_op = ALU_OR;
        i_op = ALU_OR;
      end
      default: begin
        r_ok = 1'b0;
        i_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR:   state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXEC_R:    state_d = r_ok ? S_ALU_WB : S_ILLEGAL;
      S_EXEC_I:    state_d = i_ok ? S_ALU_WB : S_ILLEGAL;
      S_JAL:       state_d = S_ALU_WB;
      S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BEQ: state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_ILLEGAL;
    endcase
  end

  assign retire = (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                  (state_q == S_ALU_WB) || (state_q == S_BEQ);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    pc_update         = 1'b0;
    branch            = 1'b0;
    ir_we             = 1'b0;
    reg_we            = 1'b0;
    mem_we            = 1'b0;
    adr_src           = 1'b0;
    alu_src_a         = 2'b00;
    alu_src_b         = 2'b00;
    result_src        = 2'b00;
    operation_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_READ:  adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a         = 2'b10;
        operation_control = r_ok ? r_op : ALU_ADD;
      end
      S_EXEC_I: begin
        alu_src_a         = 2'b10;
        alu_src_b         = 2'b01;
        operation_control = i_ok ? i_op : ALU_ADD;
      end
      S_ALU_WB:    reg_we = 1'b1;
      S_BEQ: begin
        alu_src_a         = 2'b10;
        operation_control = ALU_SUB;
        branch            = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset so an abandoned instruction never commits.
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign ir_write  = ~reset & ir_we;
  assign reg_write = ~reset & reg_we;
  assign mem_write = ~reset & mem_we;
  assign illegal   = (state_q == S_ILLEGAL);
  assign instret   = instret_q;

endmodule
